// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: core fetch, host loader and instruction-memory port signals of the arbiter.
interface imem_arbiter_if #(
  parameter int NUM_CORES       = 4,
  parameter int DATAPATH_WIDTH  = 64,
  parameter int INST_ADDR_WIDTH = 9
);
  logic                                 en;
  logic [NUM_CORES-1:0]                 core_req;
  logic [NUM_CORES*INST_ADDR_WIDTH-1:0] core_addr;
  logic [NUM_CORES-1:0]                 core_gnt;
  logic [NUM_CORES-1:0]                 core_rvalid;
  logic [DATAPATH_WIDTH-1:0]            core_rdata;
  logic                                 host_wr_en;
  logic [INST_ADDR_WIDTH-1:0]           host_wr_addr;
  logic [DATAPATH_WIDTH-1:0]            host_wr_data;
  logic                                 mem_en;
  logic                                 mem_we;
  logic [INST_ADDR_WIDTH-1:0]           mem_addr;
  logic [DATAPATH_WIDTH-1:0]            mem_wdata;
  logic [DATAPATH_WIDTH-1:0]            mem_rdata;
  modport master (
    output en, core_req, core_addr, host_wr_en, host_wr_addr, host_wr_data, mem_rdata,
    input  core_gnt, core_rvalid, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  en, core_req, core_addr, host_wr_en, host_wr_addr, host_wr_data, mem_rdata,
    output core_gnt, core_rvalid, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of one instruction memory port among cores, host writes first.
module imem_arbiter #(
  parameter int NUM_CORES       = 4,
  parameter int DATAPATH_WIDTH  = 64,
  parameter int INST_ADDR_WIDTH = 9,
  parameter int MEM_LATENCY     = 1
) (
  input logic           clk,
  input logic           reset,
  imem_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CORES);
  localparam int D  = MEM_LATENCY + 1;
  logic [IW-1:0]                r_ptr;
  logic [IW-1:0]                w_win;
  logic                         w_rd;
  logic [D-1:0]                 r_vld;
  logic [D-1:0][IW-1:0]         r_own;
  logic [NUM_CORES-1:0]         r_gnt;
  logic [NUM_CORES-1:0]         r_rvalid;
  logic [DATAPATH_WIDTH-1:0]    r_rdata;
  logic                         r_mem_en;
  logic                         r_mem_we;
  logic [INST_ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATAPATH_WIDTH-1:0]    r_mem_wdata;
  // Scan downward so the requester closest after the pointer is written last and wins.
  always_comb begin
    w_win = r_ptr;
    for (int k = NUM_CORES; k >= 1; k--)
      if (bus.core_req[IW'((int'(r_ptr) + k) % NUM_CORES)]) w_win = IW'((int'(r_ptr) + k) % NUM_CORES);
  end
  assign w_rd = bus.en && |bus.core_req && !bus.host_wr_en;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= IW'(NUM_CORES - 1);
      r_vld       <= '0;
      r_own       <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= bus.host_wr_en || w_rd;
      r_mem_we <= bus.host_wr_en;
      if (bus.host_wr_en) begin
        r_mem_addr  <= bus.host_wr_addr;
        r_mem_wdata <= bus.host_wr_data;
      end else if (w_rd) r_mem_addr <= bus.core_addr[int'(w_win)*INST_ADDR_WIDTH +: INST_ADDR_WIDTH];
      r_gnt <= w_rd ? NUM_CORES'(1) << w_win : '0;
      if (w_rd) r_ptr <= w_win;
      // Stage D-1 lines up with the cycle the memory presents the word for that read.
      r_vld    <= {r_vld[D-2:0], w_rd};
      r_own    <= {r_own[D-2:0], w_win};
      r_rvalid <= r_vld[D-1] ? NUM_CORES'(1) << r_own[D-1] : '0;
      if (r_vld[D-1]) r_rdata <= bus.mem_rdata;
    end
  end
  assign bus.core_gnt    = r_gnt;
  assign bus.core_rvalid = r_rvalid;
  assign bus.core_rdata  = r_rdata;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: two arbiters (latency 1 and 3) on identical stimulus, checked against a queue-based model.
module tb_imem_arbiter;
  localparam int N = 4, DW = 64, AW = 9;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic en = 1'b0, host = 1'b0;
  logic [N-1:0] req = '0;
  logic [AW-1:0] addr [N];
  logic [AW-1:0] haddr = '0;
  logic [DW-1:0] hdata = '0;
  logic [N*AW-1:0] ca;
  imem_arbiter_if #(.NUM_CORES(N), .DATAPATH_WIDTH(DW), .INST_ADDR_WIDTH(AW)) b0 ();
  imem_arbiter_if #(.NUM_CORES(N), .DATAPATH_WIDTH(DW), .INST_ADDR_WIDTH(AW)) b1 ();
  imem_arbiter #(.NUM_CORES(N), .DATAPATH_WIDTH(DW), .INST_ADDR_WIDTH(AW), .MEM_LATENCY(1))
    u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  imem_arbiter #(.NUM_CORES(N), .DATAPATH_WIDTH(DW), .INST_ADDR_WIDTH(AW), .MEM_LATENCY(3))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  always_comb begin
    ca = '0;
    for (int i = 0; i < N; i++) ca[i*AW +: AW] = addr[i];
  end
  assign b0.en = en;             assign b1.en = en;
  assign b0.core_req = req;      assign b1.core_req = req;
  assign b0.core_addr = ca;      assign b1.core_addr = ca;
  assign b0.host_wr_en = host;   assign b1.host_wr_en = host;
  assign b0.host_wr_addr = haddr; assign b1.host_wr_addr = haddr;
  assign b0.host_wr_data = hdata; assign b1.host_wr_data = hdata;
  // memories driven by each DUT's port
  logic [DW-1:0] mem0 [512], mem1 [512], mdl [512];
  logic [DW-1:0] p0, p1 [3];
  function automatic logic [DW-1:0] init_w(int i);
    return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'hA5A5_0000};
  endfunction
  initial for (int i = 0; i < 512; i++) begin
    mem0[i] <= init_w(i);
    mem1[i] <= init_w(i);
    mdl[i] = init_w(i);
  end
  always @(posedge clk) begin
    p0 <= (b0.mem_en && !b0.mem_we) ? mem0[b0.mem_addr] : '0;
    if (b0.mem_en && b0.mem_we) mem0[b0.mem_addr] <= b0.mem_wdata;
    p1[0] <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr] : '0;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
  end
  assign b0.mem_rdata = p0;
  assign b1.mem_rdata = p1[2];
  // reference model state
  typedef struct { int owner; logic [DW-1:0] data; int due; } rd_t;
  rd_t q0 [$], q1 [$];
  int ptr, cyc, checks, failures;
  logic [N-1:0] e_gnt, e_rv0, e_rv1;
  logic e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd0, e_rd1;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    ptr = N - 1; e_gnt = '0; e_rv0 = '0; e_rv1 = '0; e_en = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    q0.delete(); q1.delete();
  endtask
  task automatic cmp_all();
    chk("gnt_l1", b0.core_gnt, e_gnt);       chk("gnt_l3", b1.core_gnt, e_gnt);
    chk("mem_en_l1", b0.mem_en, e_en);       chk("mem_en_l3", b1.mem_en, e_en);
    chk("mem_we_l1", b0.mem_we, e_we);       chk("mem_we_l3", b1.mem_we, e_we);
    chk("mem_addr_l1", b0.mem_addr, e_addr); chk("mem_addr_l3", b1.mem_addr, e_addr);
    chk("mem_wdata_l1", b0.mem_wdata, e_wdata); chk("mem_wdata_l3", b1.mem_wdata, e_wdata);
    chk("rvalid_l1", b0.core_rvalid, e_rv0); chk("rvalid_l3", b1.core_rvalid, e_rv1);
    chk("rdata_l1", b0.core_rdata, e_rd0);   chk("rdata_l3", b1.core_rdata, e_rd1);
  endtask
  // one clock: model the edge from the inputs now applied, then compare at the falling edge
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) model_reset();
    else begin
      e_gnt = '0;
      if (host) begin
        e_en = 1; e_we = 1; e_addr = haddr; e_wdata = hdata; mdl[haddr] = hdata;
      end else if (en && req != '0) begin
        int w;
        w = -1;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (ptr + k) % N;
          if (w < 0 && req[c]) w = c;
        end
        ptr = w; e_en = 1; e_we = 0; e_addr = addr[w]; e_gnt[w] = 1'b1;
        q0.push_back('{w, mdl[addr[w]], cyc + 2});
        q1.push_back('{w, mdl[addr[w]], cyc + 4});
      end else begin
        e_en = 0; e_we = 0;
      end
      e_rv0 = '0; e_rv1 = '0;
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e_rv0[q0[0].owner] = 1'b1; e_rd0 = q0[0].data; void'(q0.pop_front());
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e_rv1[q1[0].owner] = 1'b1; e_rd1 = q1[0].data; void'(q1.pop_front());
      end
    end
    @(negedge clk);
    cmp_all();
  endtask
  task automatic idle(int n);
    req = '0; host = 0;
    for (int i = 0; i < n; i++) step();
  endtask
  typedef struct { logic en; logic [N-1:0] req; logic host; logic [N-1:0] gnt; logic we; logic [N-1:0] rv; } vec_t;
  vec_t tbl [12];
  int cnt0, cnt1, cnt3;
  logic [N-1:0] gq [$], rq [$];
  logic [N-1:0] prev;
  initial begin
    tbl[0]  = '{1, 4'b0000, 0, 4'b0000, 0, 4'b0000};
    tbl[1]  = '{1, 4'b1111, 0, 4'b0001, 0, 4'b0000};
    tbl[2]  = '{1, 4'b1111, 0, 4'b0010, 0, 4'b0000};
    tbl[3]  = '{1, 4'b1111, 0, 4'b0100, 0, 4'b0001};
    tbl[4]  = '{1, 4'b1111, 0, 4'b1000, 0, 4'b0010};
    tbl[5]  = '{1, 4'b1111, 0, 4'b0001, 0, 4'b0100};
    tbl[6]  = '{1, 4'b1000, 0, 4'b1000, 0, 4'b1000};
    tbl[7]  = '{1, 4'b0011, 1, 4'b0000, 1, 4'b0001};
    tbl[8]  = '{1, 4'b0011, 0, 4'b0001, 0, 4'b1000};
    tbl[9]  = '{1, 4'b0010, 0, 4'b0010, 0, 4'b0000};
    tbl[10] = '{1, 4'b0000, 0, 4'b0000, 0, 4'b0001};
    tbl[11] = '{1, 4'b0000, 0, 4'b0000, 0, 4'b0010};
    checks = 0; failures = 0; cyc = 0;
    model_reset();
    addr[0] = 9'h1FF; addr[1] = 9'h021; addr[2] = 9'h022; addr[3] = 9'h023;
    // reset held, then released with no requests: everything stays zero
    step(); step();
    reset = 1'b1;
    step();
    chk("reset_mem_en", b0.mem_en, 1'b0);
    haddr = 9'h1FF; hdata = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; req = tbl[i].req; host = tbl[i].host;
      step();
      chk($sformatf("tbl%0d_gnt", i), b0.core_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_we", i), b0.mem_we, tbl[i].we);
      chk($sformatf("tbl%0d_rv", i), b0.core_rvalid, tbl[i].rv);
      if (i == 10) chk("host_readback", b0.core_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    end
    idle(6);
    // single requester: core 2, five back-to-back reads
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 5; i++) begin
      req = 4'b0100; addr[2] = AW'(9'h010 + i);
      step();
      chk("single_gnt", b0.core_gnt, 4'b0100);
      if (b0.core_rvalid == 4'b0100) cnt0++;
      if (b1.core_rvalid == 4'b0100) cnt1++;
    end
    req = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b0.core_rvalid == 4'b0100) cnt0++;
      if (b1.core_rvalid == 4'b0100) cnt1++;
    end
    chk("single_rv_cnt_l1", cnt0, 5);
    chk("single_rv_cnt_l3", cnt1, 5);
    chk("single_last_data", b0.core_rdata, mdl[9'h014]);
    // fairness: cores 1 and 3 requesting continuously
    req = 4'b1010; gq.delete(); rq.delete(); cnt1 = 0; cnt3 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i > 0) chk("fair_alt", b0.core_gnt, prev == 4'b0010 ? 4'b1000 : 4'b0010);
      prev = b0.core_gnt;
      gq.push_back(b0.core_gnt);
      if (b0.core_gnt == 4'b0010) cnt1++;
      if (b0.core_gnt == 4'b1000) cnt3++;
      if (b1.core_rvalid != '0) rq.push_back(b1.core_rvalid);
    end
    req = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b1.core_rvalid != '0) rq.push_back(b1.core_rvalid);
    end
    chk("fair_cnt1", cnt1, 4);
    chk("fair_cnt3", cnt3, 4);
    chk("fair_rv_len", rq.size(), 8);
    for (int i = 0; i < 8 && i < rq.size(); i++) chk($sformatf("fair_rv_order%0d", i), rq[i], gq[i]);
    // en gating with two reads in flight
    req = 4'b1100; step();
    req = 4'b1000 & ~b0.core_gnt; step();
    en = 0; req = 4'b0001; cnt0 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gate_no_gnt", b0.core_gnt, 4'b0000);
      if (b0.core_rvalid != '0) cnt0++;
    end
    chk("gate_inflight_rv", cnt0, 2);
    en = 1; step();
    chk("gate_resume_gnt", b0.core_gnt, 4'b0001);
    idle(6);
    // reset one cycle after a grant to core 1
    req = 4'b0010; step();
    chk("midrst_gnt", b0.core_gnt, 4'b0010);
    req = '0; reset = 1'b0;
    #1;
    model_reset();
    cmp_all();
    chk("midrst_gnt_zero", b0.core_gnt, 4'b0000);
    chk("midrst_mem_en_zero", b0.mem_en, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_no_rv", b1.core_rvalid, 4'b0000);
    end
    reset = 1'b1; req = 4'b1111;
    step();
    chk("midrst_core0_first", b0.core_gnt, 4'b0001);
    idle(6);
    // randomized traffic; requests held until granted
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] || e_gnt[i]) begin
          req[i] = ($urandom % 4) != 0;
          addr[i] = AW'($urandom);
        end
      en = ($urandom % 8) != 0;
      host = ($urandom % 10) == 0;
      haddr = AW'($urandom);
      hdata = {$urandom, $urandom};
      step();
    end
    en = 1;
    idle(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
